// File: rtl/tbus_arb_pkg.sv
// Shared types and width helpers for the tri-state bus arbiter.
// Bus parking is built in when TBUS_ARB_PARK_EN is defined.
package tbus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    TURN,
    PARK
  } arb_state_t;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int TA_CYC_DEF   = 2;
  localparam int MAX_HOLD_DEF = 8;
  localparam int TA_W_DEF     = cnt_w(TA_CYC_DEF);
  localparam int HOLD_W_DEF   = cnt_w(MAX_HOLD_DEF);

endpackage

// File: rtl/tbus_rr_pick.sv
// Round-robin winner search: first set request at or above ptr, with wrap.
// Purely combinational; shared by every arbitration point of the sequencer.
module tbus_rr_pick
  import tbus_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]       req,
  input  logic [id_w(NREQ)-1:0] ptr,
  output logic [id_w(NREQ)-1:0] id,
  output logic                  vld
);

  localparam int IW = id_w(NREQ);

  logic [IW-1:0] j;

  always_comb begin
    id  = '0;
    vld = 1'b0;
    j   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = IW'((int'(ptr) + i) % NREQ);
      if (!vld && req[j]) begin
        vld = 1'b1;
        id  = j;
      end
    end
  end

endmodule

// File: rtl/tbus_arbiter.sv
// Round-robin owner sequencer for a bufz-driven shared bus with all-off gaps.
// Optional bus parking: define TBUS_ARB_PARK_EN.
module tbus_arbiter
  import tbus_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int TA_CYC   = TA_CYC_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                  CLK,
  input  logic                  RN,
  input  logic [NREQ-1:0]       REQ,
  output logic [NREQ-1:0]       EN,
  output logic [id_w(NREQ)-1:0] GNT_ID,
  output logic                  GNT_VLD,
  output logic                  BUS_FLOAT
);

  localparam int IW = id_w(NREQ);
  localparam int TW = cnt_w(TA_CYC);
  localparam int HW = cnt_w(MAX_HOLD);

  localparam logic [TW-1:0] TURN_LAST = TW'(TA_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [IW-1:0] ID_LAST = IW'(NREQ - 1);

  if (TA_CYC < 1) begin : g_bad_ta
    $error("tbus_arbiter: TA_CYC must be >= 1");
  end
  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("tbus_arbiter: NREQ must be 2..16");
  end

  arb_state_t    state_q, state_d;
  logic [NREQ-1:0] en_q, en_d;
  logic [IW-1:0] id_q, id_d;
  logic          vld_q, vld_d;
  logic          flt_q, flt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic [IW-1:0]   pk_id;
  logic            pk_vld;
  logic [NREQ-1:0] oth;
  logic            own;
  logic            hold_rel;
  logic            do_grant;
  logic            do_off;

  tbus_rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req(REQ),
    .ptr(ptr_q),
    .id (pk_id),
    .vld(pk_vld)
  );

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      en_q    <= '0;
      id_q    <= '0;
      vld_q   <= 1'b0;
      flt_q   <= 1'b1;
      ptr_q   <= '0;
      hcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      flt_q   <= flt_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    id_d     = id_q;
    vld_d    = vld_q;
    flt_d    = flt_q;
    ptr_d    = ptr_q;
    hcnt_d   = hcnt_q;
    tcnt_d   = tcnt_q;
    do_grant = 1'b0;
    do_off   = 1'b0;

    oth        = REQ;
    oth[id_q]  = 1'b0;
    own        = REQ[id_q];
    hold_rel   = (MAX_HOLD != 0) && (hcnt_q == HOLD_LAST) && (|oth);

    unique case (state_q)
      IDLE: begin
        if (pk_vld) do_grant = 1'b1;
      end
      OWN: begin
        if (!own || hold_rel) begin
          ptr_d  = (id_q == ID_LAST) ? '0 : id_q + 1'b1;
          hcnt_d = '0;
`ifdef TBUS_ARB_PARK_EN
          if (|oth) do_off = 1'b1;
          else      state_d = PARK;
`else
          do_off = 1'b1;
`endif
        end else if (MAX_HOLD != 0 && hcnt_q != HOLD_LAST) begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      TURN: begin
        if (tcnt_q == TURN_LAST) begin
          if (pk_vld) do_grant = 1'b1;
          else        state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      PARK: begin
`ifdef TBUS_ARB_PARK_EN
        // Parked driver stays on; only a different winner forces a gap.
        if (pk_vld) begin
          if (pk_id == id_q) begin
            state_d = OWN;
            hcnt_d  = '0;
          end else begin
            do_off = 1'b1;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (do_grant) begin
      state_d     = OWN;
      en_d        = '0;
      en_d[pk_id] = 1'b1;
      id_d        = pk_id;
      vld_d       = 1'b1;
      flt_d       = 1'b0;
      hcnt_d      = '0;
    end
    if (do_off) begin
      state_d = TURN;
      en_d    = '0;
      vld_d   = 1'b0;
      flt_d   = 1'b1;
      tcnt_d  = '0;
    end
  end

  assign EN        = en_q;
  assign GNT_ID    = id_q;
  assign GNT_VLD   = vld_q;
  assign BUS_FLOAT = flt_q;

endmodule

// File: tb/tb_tbus_arbiter.sv
// Directed bench for tbus_arbiter (NREQ=4, TA_CYC=2, MAX_HOLD=8).
// Vector table plus hand sequences; a negedge monitor guards one-hot and gaps.
module tb_tbus_arbiter;

  localparam int TA = 2;

  logic       CLK = 1'b0;
  logic       RN  = 1'b0;
  logic [3:0] REQ = '0;
  logic [3:0] EN;
  logic [1:0] GNT_ID;
  logic       GNT_VLD;
  logic       BUS_FLOAT;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  tbus_arbiter #(
    .NREQ    (4),
    .TA_CYC  (2),
    .MAX_HOLD(8)
  ) dut (
    .CLK      (CLK),
    .RN       (RN),
    .REQ      (REQ),
    .EN       (EN),
    .GNT_ID   (GNT_ID),
    .GNT_VLD  (GNT_VLD),
    .BUS_FLOAT(BUS_FLOAT)
  );

  function automatic int idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RN  = 1'b0;
    REQ = '0;
    repeat (2) tick();
    RN = 1'b1;
  endtask

  task automatic chk_out(input string nm, input logic [3:0] exp);
    chk({nm, ".en"}, 32'(EN), 32'(exp));
    chk({nm, ".flt"}, 32'(BUS_FLOAT), 32'(exp == 4'b0));
    if (exp != 4'b0) chk({nm, ".id"}, 32'(GNT_ID), 32'(idx(exp)));
  endtask

  // One-hot, flag consistency and break-before-make gap monitor
  int gap = 0;
  int last_id = 0;
  bit have_last = 1'b0;

  always @(negedge CLK) begin
    if (!RN) begin
      have_last = 1'b0;
      gap = 0;
    end else begin
      n_cmp++;
      if ($countones(EN) > 1) begin
        n_bad++;
        $display("FAIL onehot: EN=%b want popcount<=1", EN);
      end
      n_cmp++;
      if (GNT_VLD !== (|EN) || BUS_FLOAT !== ~GNT_VLD) begin
        n_bad++;
        $display("FAIL flags: EN=%b VLD=%b FLT=%b", EN, GNT_VLD,
                 BUS_FLOAT);
      end
      if (EN != 4'b0) begin
        if (have_last && idx(EN) != last_id) begin
          n_cmp++;
          if (gap < TA) begin
            n_bad++;
            $display("FAIL gap: got %0d idle cycles want >=%0d",
                     gap, TA);
          end
        end
        last_id = idx(EN);
        have_last = 1'b1;
        gap = 0;
      end else begin
        gap++;
      end
    end
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] en;
  } vec_t;

  vec_t       tbl[18];
  logic [3:0] e;
  int         p;
  int         o;

  initial begin
    tbl[0]  = '{4'b0010, 4'b0010};
    tbl[1]  = '{4'b0010, 4'b0010};
    tbl[2]  = '{4'b0010, 4'b0010};
    tbl[3]  = '{4'b0010, 4'b0010};
    tbl[4]  = '{4'b0010, 4'b0010};
    tbl[5]  = '{4'b0000, 4'b0000};
    tbl[6]  = '{4'b0000, 4'b0000};
    tbl[7]  = '{4'b0000, 4'b0000};
    tbl[8]  = '{4'b0001, 4'b0001};
    tbl[9]  = '{4'b0001, 4'b0001};
    tbl[10] = '{4'b0001, 4'b0001};
    tbl[11] = '{4'b0101, 4'b0001};
    tbl[12] = '{4'b0100, 4'b0000};
    tbl[13] = '{4'b0100, 4'b0000};
    tbl[14] = '{4'b0100, 4'b0100};
    tbl[15] = '{4'b0000, 4'b0000};
    tbl[16] = '{4'b0000, 4'b0000};
    tbl[17] = '{4'b0000, 4'b0000};

    do_reset();
    chk_out("rst", 4'b0);
    chk("rst.vld", 32'(GNT_VLD), 32'd0);
    chk("rst.id", 32'(GNT_ID), 32'd0);

    // Async reset in the middle of an ownership
    REQ = 4'b0100;
    tick();
    chk_out("t1.own", 4'b0100);
    #2 RN = 1'b0;
    #1;
    chk_out("t1.async", 4'b0);
    chk("t1.vld", 32'(GNT_VLD), 32'd0);
    chk("t1.id", 32'(GNT_ID), 32'd0);
    REQ = 4'b0;
    tick();
    RN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_out($sformatf("t1.idle%0d", c), 4'b0);
    end

`ifndef TBUS_ARB_PARK_EN
    do_reset();
    for (int i = 0; i < 18; i++) begin
      REQ = tbl[i].req;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].en);
    end
`endif

    // All four requesting: 8-cycle slots, 2-cycle gaps, wrap to 0
    do_reset();
    REQ = 4'b1111;
    for (int c = 1; c <= 48; c++) begin
      tick();
      p = (c - 1) % 10;
      o = ((c - 1) / 10) % 4;
      e = (p < 8) ? 4'(1 << o) : 4'b0;
      chk_out($sformatf("rr.c%0d", c), e);
    end

    // Lone requester never hits the hold limit; saturated count
    // releases at once when a second requester shows up
    do_reset();
    REQ = 4'b0001;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk_out($sformatf("solo.c%0d", c), 4'b0001);
    end
    REQ = 4'b0011;
    tick();
    chk_out("solo.rel", 4'b0);
    tick();
    chk_out("solo.ta", 4'b0);
    tick();
    chk_out("solo.next", 4'b0010);

`ifdef TBUS_ARB_PARK_EN
    do_reset();
    REQ = 4'b0010;
    tick();
    chk_out("park.c1", 4'b0010);
    tick();
    chk_out("park.c2", 4'b0010);
    tick();
    chk_out("park.c3", 4'b0010);
    REQ = 4'b0000;
    tick();
    chk_out("park.c4", 4'b0010);
    tick();
    chk_out("park.c5", 4'b0010);
    REQ = 4'b0010;
    tick();
    chk_out("park.reown", 4'b0010);
    tick();
    chk_out("park.c7", 4'b0010);
    REQ = 4'b0000;
    tick();
    chk_out("park.c8", 4'b0010);
    REQ = 4'b1000;
    tick();
    chk_out("park.off1", 4'b0);
    tick();
    chk_out("park.off2", 4'b0);
    tick();
    chk_out("park.new", 4'b1000);
`endif

    REQ = 4'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tbus_arbiter.md
Name: tbus_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared tri-state bus built from bufz_* drivers, one driver per requester.
- Produces one-hot registered EN for the driver cells and guarantees break-before-make: never two drivers enabled, with a programmable all-off turnaround gap between owners.
- Sits beside the bus macro and replaces ad-hoc enable glue in pad-ring and shared-bus designs.

Parameters:
- NREQ, 4, number of requesters/drivers (2..16).
- TA_CYC, 2, all-off turnaround cycles between different owners (>=1; 0 illegal, elaboration error).
- MAX_HOLD, 8, maximum ownership cycles while others wait; 0 = unlimited.

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  asynchronous active-low reset.
- REQ  input  NREQ  per-requester bus request, level, sampled on CLK.
- EN  output  NREQ  one-hot-or-zero enable to bufz EN pins, registered.
- GNT_ID  output  $clog2(NREQ)  index of current owner; valid when GNT_VLD=1.
- GNT_VLD  output  1  some EN bit set.
- BUS_FLOAT  output  1  no driver enabled (= ~GNT_VLD); drives external keeper enable.

Behaviour:
- Reset (RN=0, async): EN=0, GNT_ID=0, GNT_VLD=0, BUS_FLOAT=1, state IDLE, rr pointer=0, hold counter=0. Outputs drop immediately, not at next edge. Deassertion is synchronised by the integrator.
- States IDLE, OWN, TURN. All outputs come from flops; no comb path REQ->EN.
- IDLE: if any REQ, pick the first set bit searching from pointer upward with wrap; go to OWN. EN[g] rises at the next edge after REQ seen (1-cycle latency).
- OWN: EN[g]=1, hold counter increments each cycle. Release when:
  - REQ[g]=0, or
  - MAX_HOLD!=0, counter==MAX_HOLD-1 and any other REQ set.
- If only g requests at MAX_HOLD, ownership continues and the counter saturates.
- On release: EN=0 at the next edge, pointer=g+1 mod NREQ, counter cleared, go TURN.
- TURN: EN=0 for exactly TA_CYC cycles.
  - Last TURN cycle with REQ pending: arbitrate as in IDLE, EN asserts at the following edge.
  - Last TURN cycle with no REQ: go IDLE.
- The released owner may win again only if round-robin order reaches it.
- REQ pulses shorter than one cycle are ignored. REQ dropping during TURN is ignored for that requester.
- Invariant: popcount(EN)<=1 always. Any change of EN owner has >=TA_CYC cycles with EN==0 between.

Optional Feature:
- Macro TBUS_ARB_PARK_EN.
- Defined: bus parking. When the owner releases with no other REQ pending, EN[g] stays set, BUS_FLOAT stays 0 and the state is PARK.
  - Parked owner re-requests: OWN immediately, no turnaround, EN unchanged.
  - Another requester requests: EN=0 next edge, then TURN, then grant.
- Not parked until the first grant after reset.
- Undefined: no PARK state; behaviour exactly as above.

Decomposition:
- Package tbus_arb_pkg: state enum typedef (IDLE, OWN, TURN, PARK), counter width constants derived from TA_CYC/MAX_HOLD, ID width function.
- One combinational sub-module, tbus_rr_pick: inputs REQ vector and pointer; outputs winner index and valid flag. Reused in IDLE, end of TURN and PARK.

Test Plan:
All scenarios use NREQ=4, TA_CYC=2, MAX_HOLD=8.
1. RN=0 mid-run with EN=0100 -> EN=0000, BUS_FLOAT=1 within the same cycle, with no clock edge needed; after release with REQ=0000, outputs stay idle.
2. REQ=0010 from cycle 0 -> EN=0010, GNT_ID=1 at cycle 1; REQ drops cycle 5 -> EN=0000 cycle 6; IDLE after 2 turnaround cycles.
3. REQ=1111 held -> owners 0,1,2,3,0 in turn, each EN pulse 8 cycles, separated by exactly 2 cycles of EN=0000.
4. Requester 0 owning, REQ[2] rises cycle 3, REQ[0] falls cycle 4 -> EN=0000 cycles 5-6, EN=0100 cycle 7.
5. REQ=0001 alone for 20 cycles -> EN=0001 continuously with no MAX_HOLD release; a scoreboard asserts popcount(EN)<=1 every cycle in all tests.
6. With TBUS_ARB_PARK_EN: REQ[1] pulse 3 cycles -> EN remains 0010 after release; REQ[1] again -> no EN gap; REQ[3] -> EN=0000 for 2 cycles then 1000.
